cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- 16-bit execution datapath of the simple-RISC CPU: 8×16 register file, A/B operand registers, B-path shifter, operand-select muxes, 4-function ALU, C result register, 3-bit status register.
- Purely control-driven. The FSM controller drives every load, select and write strobe; this block contains no sequencing of its own.

Parameters:
- none. Data width 16, register count 8, imm5 width 5, all fixed.

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- readnum  in  3  register-file read address (combinational read).
- writenum  in  3  register-file write address.
- write  in  1  register-file write enable.
- vsel  in  2  write-data select: 00=C, 01=pc, 10=sximm8, 11=mdata.
- loada  in  1  load A register from read data.
- loadb  in  1  load B register from read data.
- shift  in  2  B shifter: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- asel  in  1  1: Ain=0; 0: Ain=A.
- bsel  in  1  1: Bin=sign-extended imm5; 0: Bin=shifted B.
- ALUop  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN.
- loadc  in  1  load C from ALU output.
- loads  in  1  load status from ALU flags.
- imm5  in  5  immediate operand.
- sximm8  in  16  sign-extended 8-bit immediate.
- pc  in  16  program counter value.
- mdata  in  16  memory read data.
- c  out  16  C register (datapath result).
- status_out  out  3  {Z, V, N}: bit2=Z, bit1=V, bit0=N.

Behaviour:
- Reset: on posedge with reset=1, set R0–R7, A, B, C and status to 0. Reset overrides all load and write strobes.
- Register file
  - Read: combinational, data_out = R[readnum].
  - Write: on posedge when write=1, R[writenum] ← vsel-mux value.
  - The write mux uses the C value held before the edge. Write and loadc in the same cycle writes the old C.
  - Same-cycle read/write of the same register reads the old value.
- A/B registers: on posedge, A ← data_out if loada; B ← data_out if loadb. Otherwise hold.
- Shifter, applied to B only:
  - LSL1: {B[14:0],0}.
  - LSR1: {0,B[15:1]}.
  - ASR1: {B[15],B[15:1]}.
- Operand muxes:
  - Ain = asel ? 0 : A.
  - Bin = bsel ? {{11{imm5[4]}},imm5} : sout.
- ALU, 16-bit, wraps modulo 2^16:
  - ADD: Ain+Bin.
  - SUB: Ain−Bin.
  - AND: Ain&Bin.
  - MVN: ~Bin.
- Flags, computed combinationally from the ALU result:
  - Z = result==0.
  - N = result[15].
  - V for ADD: Ain[15]==Bin[15] && result[15]!=Ain[15].
  - V for SUB: Ain[15]!=Bin[15] && result[15]!=Ain[15].
  - V = 0 for AND and MVN.
- C and status: on posedge, C ← ALU result if loadc; status ← {Z,V,N} if loads. loadc and loads are independent; each register holds when its load is 0.
- Latency: a register value reaches c two edges after the loada/loadb edge (loadA/B edge, then loadC edge). Write-back needs one more edge with vsel=00, write=1.
- Outputs are registered with no combinational path from inputs. c and status_out change only on posedge.

Decomposition:
- Shared package: ALUop, shift and vsel encodings as named constants; status bit indices Z=2, V=1, N=0.
- One sub-module: cpu_regfile, 8×16 storage, instantiated as REGFILE with registers named R0..R7 so benches can probe them hierarchically.
- Shifter, ALU and muxes stay inline.

Test Plan:
- Immediate write: reset, then write=1, vsel=10, writenum=0, sximm8=50 → R0=50. Repeat with writenum=1, sximm8=21 → R1=21.
- ALU ops:
  - loadA from R0, loadB from R1, ADD with loadc/loads → c=71, status=000.
  - SUB → c=29, status=000.
  - AND → c=16, status=000.
  - Write back with vsel=00 → destination register = c.
- Shifts:
  - asel=1, B=R2(71), LSR1 → c=35.
  - ADD R2 + (R3=29)<<1 → c=129.
  - SUB 71−(35>>1) → c=54.
  - SUB 54−(54<<1) → c=−54, status=001.
  - SUB x−x → c=0, status=100.
  - ASR1 of 0x8000 → c=0xC000.
- MVN and immediate: R7=6; MVN → c=0xFFF9, status=001. Then bsel=1, imm5=1, ADD → −6, status=001. Then imm5=10 → 4, status=000. Also imm5=5'b11111 adds −1.
- Overflow and hold:
  - 0x7FFF+1 → c=0x8000, status=011.
  - 0x8000−1 → c=0x7FFF, status=010.
  - loadc=0 with new A/B loaded → c unchanged.
  - loads=0 → status unchanged.
  - loadc=1 with loada=loadb=0 → c recomputed from held A/B.
- Reset mid-operation: reset asserted alongside loadc=1 and write=1 → c=0, status=000, all R=0 on that edge.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// Shared encodings for the CPU execution datapath: ALU ops, shifter modes,
// write-back source selects and status bit positions.
package cpu_datapath_pkg;
  localparam int DW = 16;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam int ST_Z = 2;
  localparam int ST_V = 1;
  localparam int ST_N = 0;
endpackage

// File: rtl/cpu_datapath_regfile.sv
// 8x16 register file: combinational read, synchronous write.
// Registers are discrete (R0..R7) so they can be probed by name.
module cpu_regfile
  import cpu_datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_write,
  input  logic [2:0]    i_writenum,
  input  logic [2:0]    i_readnum,
  input  logic [DW-1:0] i_data_in,
  output logic [DW-1:0] o_data_out
);
  logic [DW-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

  // Write port; reset clears every register and beats any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      R0 <= '0; R1 <= '0; R2 <= '0; R3 <= '0;
      R4 <= '0; R5 <= '0; R6 <= '0; R7 <= '0;
    end else if (i_write) begin
      case (i_writenum)
        3'd0: R0 <= i_data_in;
        3'd1: R1 <= i_data_in;
        3'd2: R2 <= i_data_in;
        3'd3: R3 <= i_data_in;
        3'd4: R4 <= i_data_in;
        3'd5: R5 <= i_data_in;
        3'd6: R6 <= i_data_in;
        default: R7 <= i_data_in;
      endcase
    end
  end

  // Read port; a same-edge write is not visible until after the edge.
  always_comb begin
    case (i_readnum)
      3'd0: o_data_out = R0;
      3'd1: o_data_out = R1;
      3'd2: o_data_out = R2;
      3'd3: o_data_out = R3;
      3'd4: o_data_out = R4;
      3'd5: o_data_out = R5;
      3'd6: o_data_out = R6;
      default: o_data_out = R7;
    endcase
  end
endmodule

// File: rtl/cpu_datapath.sv
// 16-bit execution datapath: register file, A/B operand registers, B-path
// shifter, operand muxes, 4-function ALU, C result and {Z,V,N} status.
// Every load/select comes from the external controller.
module cpu_datapath
  import cpu_datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    readnum,
  input  logic [2:0]    writenum,
  input  logic          write,
  input  logic [1:0]    vsel,
  input  logic          loada,
  input  logic          loadb,
  input  logic [1:0]    shift,
  input  logic          asel,
  input  logic          bsel,
  input  logic [1:0]    ALUop,
  input  logic          loadc,
  input  logic          loads,
  input  logic [4:0]    imm5,
  input  logic [DW-1:0] sximm8,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] mdata,
  output logic [DW-1:0] c,
  output logic [2:0]    status_out
);
  logic [DW-1:0] r_a, r_b, r_c;
  logic [2:0]    r_status;
  logic [DW-1:0] w_wdata, w_rdata, w_sout, w_ain, w_bin, w_alu;
  logic          w_v;

  // Write-back source; C here is the pre-edge value, so write+loadc stores old C.
  always_comb begin
    case (vsel)
      VSEL_C:   w_wdata = r_c;
      VSEL_PC:  w_wdata = pc;
      VSEL_IMM: w_wdata = sximm8;
      default:  w_wdata = mdata;
    endcase
  end

  cpu_regfile REGFILE (
    .clk        (clk),
    .reset      (reset),
    .i_write    (write),
    .i_writenum (writenum),
    .i_readnum  (readnum),
    .i_data_in  (w_wdata),
    .o_data_out (w_rdata)
  );

  // Operand registers capture register-file read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (loada) r_a <= w_rdata;
      if (loadb) r_b <= w_rdata;
    end
  end

  // Single-bit shifter on the B path only.
  always_comb begin
    case (shift)
      SH_LSL1: w_sout = {r_b[DW-2:0], 1'b0};
      SH_LSR1: w_sout = {1'b0, r_b[DW-1:1]};
      SH_ASR1: w_sout = {r_b[DW-1], r_b[DW-1:1]};
      default: w_sout = r_b;
    endcase
  end

  assign w_ain = asel ? '0 : r_a;
  assign w_bin = bsel ? {{11{imm5[4]}}, imm5} : w_sout;

  // ALU plus signed-overflow flag; AND/MVN never overflow.
  always_comb begin
    w_v = 1'b0;
    case (ALUop)
      ALU_ADD: begin
        w_alu = w_ain + w_bin;
        w_v   = (w_ain[DW-1] == w_bin[DW-1]) && (w_alu[DW-1] != w_ain[DW-1]);
      end
      ALU_SUB: begin
        w_alu = w_ain - w_bin;
        w_v   = (w_ain[DW-1] != w_bin[DW-1]) && (w_alu[DW-1] != w_ain[DW-1]);
      end
      ALU_AND: w_alu = w_ain & w_bin;
      default: w_alu = ~w_bin;
    endcase
  end

  // Result and status registers load independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c      <= '0;
      r_status <= '0;
    end else begin
      if (loadc) r_c <= w_alu;
      if (loads) begin
        r_status[ST_Z] <= (w_alu == '0);
        r_status[ST_V] <= w_v;
        r_status[ST_N] <= w_alu[DW-1];
      end
    end
  end

  assign c          = r_c;
  assign status_out = r_status;
endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: expected C/status pushed to a
// scoreboard as each ALU cycle is driven, popped after the edge.
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]  vsel, shift, ALUop;
  logic [4:0]  imm5;
  logic [15:0] sximm8, pc, mdata, c;
  logic [2:0]  status_out;

  typedef struct {
    logic [15:0] c;
    logic [2:0]  s;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  cpu_datapath dut (
    .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .shift(shift),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .imm5(imm5), .sximm8(sximm8), .pc(pc), .mdata(mdata), .c(c),
    .status_out(status_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; write = 1'b0; loada = 1'b0; loadb = 1'b0;
    loadc = 1'b0; loads = 1'b0; asel = 1'b0; bsel = 1'b0;
    shift = SH_NONE; ALUop = ALU_ADD; vsel = VSEL_C; imm5 = '0;
    readnum = '0; writenum = '0; sximm8 = 16'hDEAD; pc = 16'h0BAD; mdata = 16'hF00D;
  endtask

  // Register write; unselected sources carry distinct junk.
  task automatic wr(input logic [2:0] n, input logic [1:0] vs, input logic [15:0] val);
    writenum = n; vsel = vs; write = 1'b1;
    if (vs == VSEL_IMM)   sximm8 = val;
    if (vs == VSEL_PC)    pc     = val;
    if (vs == VSEL_MDATA) mdata  = val;
    tick();
    idle();
  endtask

  task automatic ldab(input logic [2:0] ra, input logic [2:0] rb);
    readnum = ra; loada = 1'b1; tick(); idle();
    readnum = rb; loadb = 1'b1; tick(); idle();
  endtask

  // One ALU cycle; caller may pre-set write/loada/etc. for the same edge.
  task automatic op(input logic [1:0] alu, input logic [1:0] sh, input logic as,
                    input logic bs, input logic [4:0] im, input logic lc,
                    input logic ls, input logic [15:0] ec, input logic [2:0] es,
                    input string nm);
    exp_t x;
    ALUop = alu; shift = sh; asel = as; bsel = bs; imm5 = im;
    loadc = lc; loads = ls;
    x.c = ec; x.s = es; x.nm = nm;
    sb.push_back(x);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    idle();
    n_chk++; if (c !== 16'd0) begin n_fail++; $display("FAIL reset_c got=%h exp=0000", c); end
    n_chk++; if (status_out !== 3'b000) begin n_fail++; $display("FAIL reset_status got=%b exp=000", status_out); end
    n_chk++;
    if ({dut.REGFILE.R0, dut.REGFILE.R1, dut.REGFILE.R2, dut.REGFILE.R3,
         dut.REGFILE.R4, dut.REGFILE.R5, dut.REGFILE.R6, dut.REGFILE.R7} !== 128'd0) begin
      n_fail++; $display("FAIL reset_regs got=nonzero exp=all0");
    end
  endtask

  task automatic test_imm_write();
    wr(3'd0, VSEL_IMM, 16'd50);
    wr(3'd1, VSEL_IMM, 16'd21);
    wr(3'd5, VSEL_PC, 16'h1234);
    wr(3'd6, VSEL_MDATA, 16'hBEEF);
    n_chk++; if (dut.REGFILE.R0 !== 16'd50) begin n_fail++; $display("FAIL imm_R0 got=%0d exp=50", dut.REGFILE.R0); end
    n_chk++; if (dut.REGFILE.R1 !== 16'd21) begin n_fail++; $display("FAIL imm_R1 got=%0d exp=21", dut.REGFILE.R1); end
    n_chk++; if (dut.REGFILE.R5 !== 16'h1234) begin n_fail++; $display("FAIL pc_R5 got=%h exp=1234", dut.REGFILE.R5); end
    n_chk++; if (dut.REGFILE.R6 !== 16'hBEEF) begin n_fail++; $display("FAIL mdata_R6 got=%h exp=beef", dut.REGFILE.R6); end
  endtask

  task automatic test_alu();
    ldab(3'd0, 3'd1);
    op(ALU_ADD, SH_NONE, 0, 0, 0, 1, 1, 16'd71, 3'b000, "add");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    wr(3'd2, VSEL_C, 16'd0);
    op(ALU_SUB, SH_NONE, 0, 0, 0, 1, 1, 16'd29, 3'b000, "sub");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    wr(3'd3, VSEL_C, 16'd0);
    op(ALU_AND, SH_NONE, 0, 0, 0, 1, 1, 16'd16, 3'b000, "and");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    n_chk++; if (dut.REGFILE.R2 !== 16'd71 || dut.REGFILE.R3 !== 16'd29) begin
      n_fail++; $display("FAIL writeback R2=%0d/71 R3=%0d/29", dut.REGFILE.R2, dut.REGFILE.R3);
    end
  endtask

  task automatic test_shift();
    ldab(3'd2, 3'd2);
    op(ALU_ADD, SH_LSR1, 1, 0, 0, 1, 1, 16'd35, 3'b000, "lsr_asel");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    wr(3'd4, VSEL_C, 16'd0);
    ldab(3'd2, 3'd3);
    op(ALU_ADD, SH_LSL1, 0, 0, 0, 1, 1, 16'd129, 3'b000, "add_lsl");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    ldab(3'd2, 3'd4);
    op(ALU_SUB, SH_LSR1, 0, 0, 0, 1, 1, 16'd54, 3'b000, "sub_lsr");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    wr(3'd5, VSEL_C, 16'd0);
    ldab(3'd5, 3'd5);
    op(ALU_SUB, SH_LSL1, 0, 0, 0, 1, 1, 16'hFFCA, 3'b001, "sub_neg");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    op(ALU_SUB, SH_NONE, 0, 0, 0, 1, 1, 16'd0, 3'b100, "sub_zero");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    wr(3'd6, VSEL_IMM, 16'h8000);
    ldab(3'd6, 3'd6);
    op(ALU_ADD, SH_ASR1, 1, 0, 0, 1, 1, 16'hC000, 3'b001, "asr");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
  endtask

  task automatic test_mvn_imm();
    wr(3'd7, VSEL_IMM, 16'd6);
    ldab(3'd7, 3'd7);
    op(ALU_MVN, SH_NONE, 0, 0, 0, 1, 1, 16'hFFF9, 3'b001, "mvn");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    wr(3'd7, VSEL_C, 16'd0);
    ldab(3'd7, 3'd7);
    op(ALU_ADD, SH_NONE, 0, 1, 5'd1, 1, 1, 16'hFFFA, 3'b001, "imm_p1");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    wr(3'd7, VSEL_C, 16'd0);
    ldab(3'd7, 3'd7);
    op(ALU_ADD, SH_NONE, 0, 1, 5'd10, 1, 1, 16'd4, 3'b000, "imm_p10");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    op(ALU_ADD, SH_NONE, 0, 1, 5'b11111, 1, 1, 16'hFFF9, 3'b001, "imm_m1");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
  endtask

  task automatic test_overflow_hold();
    wr(3'd0, VSEL_IMM, 16'h7FFF);
    ldab(3'd0, 3'd0);
    op(ALU_ADD, SH_NONE, 0, 1, 5'd1, 1, 1, 16'h8000, 3'b011, "add_ovf");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    ldab(3'd6, 3'd6);
    op(ALU_SUB, SH_NONE, 0, 1, 5'd1, 1, 1, 16'h7FFF, 3'b010, "sub_ovf");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    // New A/B (21,21) loaded while loadc/loads are low.
    readnum = 3'd1; loada = 1'b1; loadb = 1'b1;
    op(ALU_ADD, SH_NONE, 0, 0, 0, 0, 0, 16'h7FFF, 3'b010, "hold_both");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    op(ALU_ADD, SH_NONE, 0, 0, 0, 1, 0, 16'd42, 3'b010, "hold_status");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    op(ALU_SUB, SH_NONE, 0, 0, 0, 0, 1, 16'd42, 3'b100, "hold_c");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
  endtask

  task automatic test_back_to_back();
    // Write-back of C on the same edge C reloads: register gets old C (42).
    write = 1'b1; vsel = VSEL_C; writenum = 3'd3;
    op(ALU_ADD, SH_NONE, 0, 1, 5'd1, 1, 1, 16'd22, 3'b000, "wb_and_loadc");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    n_chk++; if (dut.REGFILE.R3 !== 16'd42) begin n_fail++; $display("FAIL wb_old_c got=%0d exp=42", dut.REGFILE.R3); end
    // Same-edge read and write of R3: A captures the old value.
    write = 1'b1; vsel = VSEL_IMM; sximm8 = 16'd100; writenum = 3'd3;
    readnum = 3'd3; loada = 1'b1;
    tick(); idle();
    op(ALU_ADD, SH_NONE, 0, 1, 5'd0, 1, 1, 16'd42, 3'b000, "rw_same_reg");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    n_chk++; if (dut.REGFILE.R3 !== 16'd100) begin n_fail++; $display("FAIL rw_R3 got=%0d exp=100", dut.REGFILE.R3); end
  endtask

  task automatic test_reset_mid();
    ldab(3'd1, 3'd1);
    op(ALU_SUB, SH_NONE, 0, 0, 0, 1, 1, 16'd0, 3'b100, "pre_reset");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    op(ALU_ADD, SH_NONE, 0, 0, 0, 1, 0, 16'd42, 3'b100, "pre_reset_c");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
    reset = 1'b1; loadc = 1'b1; loads = 1'b1; write = 1'b1;
    vsel = VSEL_IMM; sximm8 = 16'h1111; writenum = 3'd0;
    tick(); idle();
    n_chk++; if (c !== 16'd0 || status_out !== 3'b000) begin n_fail++; $display("FAIL reset_mid c=%h/0000 status=%b/000", c, status_out); end
    n_chk++;
    if ({dut.REGFILE.R0, dut.REGFILE.R1, dut.REGFILE.R2, dut.REGFILE.R3,
         dut.REGFILE.R4, dut.REGFILE.R5, dut.REGFILE.R6, dut.REGFILE.R7} !== 128'd0) begin
      n_fail++; $display("FAIL reset_mid_regs got=nonzero exp=all0 R0=%h", dut.REGFILE.R0);
    end
    op(ALU_ADD, SH_NONE, 0, 0, 0, 1, 1, 16'd0, 3'b100, "post_reset_ab");
    e = sb.pop_front(); n_chk++; if (c !== e.c || status_out !== e.s) begin n_fail++; $display("FAIL %s c=%h/%h status=%b/%b", e.nm, c, e.c, status_out, e.s); end
  endtask

  initial begin
    test_reset();
    test_imm_write();
    test_alu();
    test_shift();
    test_mvn_imm();
    test_overflow_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
